hello_world_xform: RTL and testbench
====================================

Name: hello_world_xform

Overview:
- Parametrised successor to the single-register bit-flip core.
- Accepts a stream of data words, each tagged with a transform mode, over a valid/ready handshake.
- Applies one of four bit transforms and buffers the results in an internal output FIFO for a valid/ready consumer.
- Sits behind the block's TL-UL register top, which drives the request side from a write-data register and drains the response side on read. It also reports a saturating completion counter.

Parameters:
- Width, 32, data word width in bits; must be a multiple of 8 and at least 8 (elaboration-time assertion).
- Depth, 4, output FIFO depth in entries; must be at least 2 (elaboration-time assertion).
- CntW, 16, width of the completion counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request word valid.
- req_ready_o  out  1  block can accept a request.
- req_data_i  in  Width  input word.
- req_mode_i  in  2  transform select (see Behaviour).
- req_amt_i  in  $clog2(Width)  rotate amount; used in mode 2 only.
- rsp_valid_o  out  1  output FIFO non-empty.
- rsp_ready_i  in  1  consumer takes the head entry.
- rsp_data_o  out  Width  head entry data.
- busy_o  out  1  FIFO holds at least one entry.
- cnt_o  out  CntW  number of responses consumed, saturating.
- cnt_clr_i  in  1  synchronous clear of the counter.

Clock and reset:
- One clock, clk_i.
- Reset rst_ni is asynchronous and active-low.

Behaviour:
- Reset values: FIFO empty; rsp_valid_o=0; rsp_data_o=0; busy_o=0; cnt_o=0. req_ready_o=1 once out of reset, because the FIFO is empty.
- Request accept: accept occurs on a clock edge with req_valid_i & req_ready_o. On accept, the transformed word is computed combinationally and pushed into the FIFO in the same edge.
- Latency: a word accepted at edge N is visible on rsp_data_o with rsp_valid_o=1 after edge N, provided the FIFO was empty.
- Modes:
  - 0 = bitwise invert (~data).
  - 1 = bit reverse (out[i] = in[Width-1-i]).
  - 2 = rotate-left by req_amt_i; amount 0 passes the word unchanged.
  - 3 = byte swap (byte k goes to byte Width/8-1-k).
- req_ready_o is asserted exactly when the FIFO occupancy is below Depth. It must not depend combinationally on rsp_ready_i. When full, a same-cycle pop does not enable a push; ready rises the following cycle.
- Response side:
  - rsp_valid_o = occupancy != 0; rsp_data_o = head entry.
  - rsp_data_o is held stable while rsp_valid_o & !rsp_ready_i.
  - rsp_data_o is driven to 0 when empty.
- Simultaneous push and pop with 0 < occupancy < Depth: occupancy is unchanged and ordering is preserved (strict FIFO).
- Pointers wrap modulo Depth; non-power-of-2 Depth is supported.
- busy_o equals rsp_valid_o (kept as a distinct status for the register map).
- Counter:
  - cnt_o increments on each rsp handshake and saturates at 2^CntW-1 with no wrap.
  - cnt_clr_i has priority: clear and handshake in the same cycle gives cnt_o=0.
- Reset mid-operation: FIFO contents are discarded, outputs return to their reset values immediately, and the counter is cleared.
- Inputs req_mode_i and req_amt_i are sampled only on accept.

Optional Feature:
- Macro HELLO_WORLD_XFORM_PARITY_EN.
- When defined:
  - Adds output port rsp_parity_o (1 bit), even parity (XOR-reduce) of rsp_data_o.
  - The parity bit is computed at push and stored as an extra FIFO bit alongside the data.
  - rsp_parity_o is 0 when empty.
  - FIFO entries are Width+1 bits.
- When undefined: no port, and FIFO entries are Width bits.

Decomposition:
- Package hello_world_xform_pkg:
  - Enum xform_mode_e: XfInvert=0, XfReverse=1, XfRotl=2, XfBswap=3.
  - Default parameter constants.
  - Pure function xform() taking word, mode and amount.
- Sub-module hello_world_xform_fifo:
  - Synchronous FIFO parametrised by width and depth.
  - Provides wvalid/wready/rvalid/rready plus occupancy.
- The top instantiates the FIFO and owns the transform stage and the counter.

Test Plan:
- Reset, then send data=0x0000_00FF, mode 0 -> one cycle later rsp_valid_o=1, rsp_data_o=0xFFFF_FF00, busy_o=1; consume -> cnt_o=1.
- Send 0x0000_0001 with each of: mode 1; mode 2 with amt=31; mode 3 on 0x1122_3344 -> 0x8000_0000, 0x8000_0000, 0x4433_2211, in order.
- Hold rsp_ready_i=0 and push 4 words -> req_ready_o=0 after the 4th. Pulse rsp_ready_i together with req_valid_i while full -> pop only; the new push is accepted the next cycle; output order is preserved.
- Continuous push/pop with rsp_ready_i=1 over 20 words -> 20 correct outputs, ordering intact across pointer wrap, cnt_o=20.
- Preload cnt to 0xFFFE (CntW=16) and consume 3 words -> 0xFFFF saturated; assert cnt_clr_i together with a handshake -> cnt_o=0.
- Fill 3 entries, then assert rst_ni=0 asynchronously mid-cycle -> rsp_valid_o, busy_o and cnt_o drop immediately; after release req_ready_o=1 and the FIFO is empty. With the parity macro defined, 0x0000_0007 under mode 0 -> rsp_parity_o=1.

Source files
------------

// File: rtl/hello_world_xform_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hello_world_xform_pkg
// Brief   : Shared types, default parameters and the word transform function.
// Revision: 1.0 - initial release
// ============================================================================
package hello_world_xform_pkg;

    localparam int unsigned c_DEF_WIDTH = 32;
    localparam int unsigned c_DEF_DEPTH = 4;
    localparam int unsigned c_DEF_CNT_W = 16;
    localparam int unsigned c_MAX_WIDTH = 256;
    localparam int unsigned c_IDX_W     = $clog2(c_MAX_WIDTH);

    typedef enum logic [1:0] {
        XfInvert  = 2'd0,
        XfReverse = 2'd1,
        XfRotl    = 2'd2,
        XfBswap   = 2'd3
    } xform_mode_e;

    // Operates on a max-width container; only the low 'width' bits are meaningful.
    function automatic logic [c_MAX_WIDTH-1:0] xform(
        input logic [c_MAX_WIDTH-1:0] data,
        input xform_mode_e            mode,
        input int unsigned            amt,
        input int unsigned            width
    );
        logic [c_MAX_WIDTH-1:0] res;
        int unsigned            dst;
        res = '0;
        for (int unsigned i = 0; i < c_MAX_WIDTH; i++) begin
            if (i < width) begin
                case (mode)
                    XfInvert:  dst = i;
                    XfReverse: dst = width - 1 - i;
                    XfRotl:    dst = (i + amt) % width;
                    default:   dst = ((width / 8) - 1 - (i / 8)) * 8 + (i % 8);
                endcase
                res[c_IDX_W'(dst)] = (mode == XfInvert) ? ~data[c_IDX_W'(i)]
                                                        : data[c_IDX_W'(i)];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hello_world_xform_fifo.sv
`default_nettype none
// ============================================================================
// Module  : hello_world_xform_fifo
// Brief   : Synchronous valid/ready FIFO, any depth >= 2, zero output when empty.
// Revision: 1.0 - initial release
// ============================================================================
module hello_world_xform_fifo
    import hello_world_xform_pkg::*;
#(
    parameter int unsigned WIDTH = c_DEF_WIDTH,
    parameter int unsigned DEPTH = c_DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_wvalid,
    output logic                       o_wready,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic                       o_rvalid,
    input  logic                       i_rready,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned           c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned           c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0]    c_LAST  = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0]    c_FULL  = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // Ready is derived from registered occupancy only, so a pop never frees a slot in the same cycle.
    assign o_wready = (r_count < c_FULL);
    assign o_rvalid = (r_count != '0);
    assign o_rdata  = o_rvalid ? r_mem[r_rd_ptr] : '0;
    assign o_count  = r_count;
    assign w_push   = i_wvalid & o_wready;
    assign w_pop    = o_rvalid & i_rready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/hello_world_xform.sv
`default_nettype none
// ============================================================================
// Module  : hello_world_xform
// Brief   : Streaming 4-mode bit transform with output FIFO and completion
//           counter. Define HELLO_WORLD_XFORM_PARITY_EN to add rsp_parity_o.
// Revision: 1.0 - initial release
// ============================================================================
module hello_world_xform
    import hello_world_xform_pkg::*;
#(
    parameter int unsigned WIDTH = c_DEF_WIDTH,
    parameter int unsigned DEPTH = c_DEF_DEPTH,
    parameter int unsigned CNT_W = c_DEF_CNT_W
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [WIDTH-1:0]         req_data_i,
    input  logic [1:0]               req_mode_i,
    input  logic [$clog2(WIDTH)-1:0] req_amt_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [WIDTH-1:0]         rsp_data_o,
    output logic                     busy_o,
    output logic [CNT_W-1:0]         cnt_o,
    input  logic                     cnt_clr_i
`ifdef HELLO_WORLD_XFORM_PARITY_EN
    ,
    output logic                     rsp_parity_o
`endif
);

`ifdef HELLO_WORLD_XFORM_PARITY_EN
    localparam int unsigned c_ENTRY_W = WIDTH + 1;
`else
    localparam int unsigned c_ENTRY_W = WIDTH;
`endif
    localparam int unsigned c_OCC_W = $clog2(DEPTH + 1);

    if (((WIDTH % 8) != 0) || (WIDTH < 8) || (WIDTH > c_MAX_WIDTH)) begin : g_bad_width
        $error("hello_world_xform: WIDTH must be a multiple of 8 in [8, 256]");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("hello_world_xform: DEPTH must be at least 2");
    end

    logic [WIDTH-1:0]     w_xf_data;
    logic [c_ENTRY_W-1:0] w_push_entry;
    logic [c_ENTRY_W-1:0] w_head_entry;
    logic [c_OCC_W-1:0]   w_occ;
    logic                 w_rsp_hs;
    logic [CNT_W-1:0]     r_cnt;

    always_comb begin
        w_xf_data = WIDTH'(xform(c_MAX_WIDTH'(req_data_i), xform_mode_e'(req_mode_i),
                                 32'(req_amt_i), WIDTH));
    end

`ifdef HELLO_WORLD_XFORM_PARITY_EN
    assign w_push_entry = {^w_xf_data, w_xf_data};
    assign rsp_parity_o = w_head_entry[WIDTH];
`else
    assign w_push_entry = w_xf_data;
`endif

    hello_world_xform_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .i_wvalid (req_valid_i),
        .o_wready (req_ready_o),
        .i_wdata  (w_push_entry),
        .o_rvalid (rsp_valid_o),
        .i_rready (rsp_ready_i),
        .o_rdata  (w_head_entry),
        .o_count  (w_occ)
    );

    assign rsp_data_o = w_head_entry[WIDTH-1:0];
    assign busy_o     = (w_occ != '0);
    assign w_rsp_hs   = rsp_valid_o & rsp_ready_i;

    // Clear wins over a same-cycle handshake; the count sticks at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (cnt_clr_i) begin
            r_cnt <= '0;
        end else if (w_rsp_hs && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hello_world_xform.sv
`default_nettype none
// ============================================================================
// Module  : tb_hello_world_xform
// Brief   : Self-checking bench with a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hello_world_xform;

    localparam int unsigned c_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_data_i = '0;
    logic [1:0]  req_mode_i = '0;
    logic [4:0]  req_amt_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_data_o;
    logic        busy_o;
    logic [15:0] cnt_o;
    logic        cnt_clr_i = 1'b0;
`ifdef HELLO_WORLD_XFORM_PARITY_EN
    logic        rsp_parity_o;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [15:0] m_cnt = '0;

    hello_world_xform dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_data_i  (req_data_i),
        .req_mode_i  (req_mode_i),
        .req_amt_i   (req_amt_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .busy_o      (busy_o),
        .cnt_o       (cnt_o),
        .cnt_clr_i   (cnt_clr_i)
`ifdef HELLO_WORLD_XFORM_PARITY_EN
        ,
        .rsp_parity_o(rsp_parity_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_xform(input logic [31:0] d, input logic [1:0] m,
                                              input logic [4:0] a);
        logic [31:0] r;
        r = '0;
        case (m)
            2'd0: r = ~d;
            2'd1: for (int i = 0; i < 32; i++) r[i] = d[31-i];
            2'd2: r = (a == 5'd0) ? d : ((d << a) | (d >> (6'd32 - {1'b0, a})));
            default: r = {d[7:0], d[15:8], d[23:16], d[31:24]};
        endcase
        return r;
    endfunction

    // Reference model: checked and advanced on every falling edge.
    always @(negedge clk) begin
        logic hs;
        logic push;
        if (!rst_ni) begin
            exp_q.delete();
            m_cnt = '0;
        end
        chk_eq("cnt", 32'(cnt_o), 32'(m_cnt));
        chk_eq("rsp_valid", 32'(rsp_valid_o), 32'(exp_q.size() != 0));
        chk_eq("busy", 32'(busy_o), 32'(exp_q.size() != 0));
        chk_eq("req_ready", 32'(req_ready_o), 32'(exp_q.size() < c_DEPTH));
        if (exp_q.size() == 0) chk_eq("rsp_data_empty", rsp_data_o, 32'd0);
        else                   chk_eq("rsp_data", rsp_data_o, exp_q[0]);
`ifdef HELLO_WORLD_XFORM_PARITY_EN
        chk_eq("rsp_parity", 32'(rsp_parity_o),
               32'((exp_q.size() == 0) ? 1'b0 : ^exp_q[0]));
`endif
        if (rst_ni) begin
            hs   = (exp_q.size() != 0) && rsp_ready_i;
            push = req_valid_i && (exp_q.size() < c_DEPTH);
            if (hs) void'(exp_q.pop_front());
            if (push) exp_q.push_back(ref_xform(req_data_i, req_mode_i, req_amt_i));
            if (cnt_clr_i) m_cnt = '0;
            else if (hs && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] m, input logic [4:0] a);
        int waited;
        waited = 0;
        req_data_i  = d;
        req_mode_i  = m;
        req_amt_i   = a;
        req_valid_i = 1'b1;
        @(negedge clk);
        while (!req_ready_o && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready_o) chk_eq("send_timeout", 32'(req_ready_o), 32'd1);
        step();
        req_valid_i = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] exp);
        chk_eq({tag, "_valid"}, 32'(rsp_valid_o), 32'd1);
        chk_eq(tag, rsp_data_o, exp);
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
    endtask

    task automatic stream(input int n);
        req_valid_i = 1'b1;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            req_data_i = $urandom;
            req_mode_i = 2'($urandom);
            req_amt_i  = 5'($urandom);
            step();
        end
        req_valid_i = 1'b0;
        step();
        rsp_ready_i = 1'b0;
    endtask

    task automatic clear_cnt();
        cnt_clr_i = 1'b1;
        step();
        cnt_clr_i = 1'b0;
    endtask

    initial begin
        #1 rst_ni = 1'b0;
        #1;
        chk_eq("rst_valid", 32'(rsp_valid_o), 32'd0);
        chk_eq("rst_data", rsp_data_o, 32'd0);
        chk_eq("rst_busy", 32'(busy_o), 32'd0);
        chk_eq("rst_cnt", 32'(cnt_o), 32'd0);
        repeat (2) step();
        rst_ni = 1'b1;
        step();
        chk_eq("ready_after_rst", 32'(req_ready_o), 32'd1);

        // First word, mode 0
        send(32'h0000_00FF, 2'd0, 5'd0);
        chk_eq("first_valid", 32'(rsp_valid_o), 32'd1);
        chk_eq("first_busy", 32'(busy_o), 32'd1);
        pop_expect("first_data", 32'hFFFF_FF00);
        chk_eq("first_cnt", 32'(cnt_o), 32'd1);

        // One word per remaining mode
        send(32'h0000_0001, 2'd1, 5'd0);
        send(32'h0000_0001, 2'd2, 5'd31);
        send(32'h1122_3344, 2'd3, 5'd0);
        pop_expect("mode_rev", 32'h8000_0000);
        pop_expect("mode_rotl", 32'h8000_0000);
        pop_expect("mode_bswap", 32'h4433_2211);

        // Full FIFO: a pop while full does not admit a push in the same cycle
        for (int i = 0; i < 4; i++) send($urandom, 2'($urandom), 5'($urandom));
        chk_eq("full_ready_low", 32'(req_ready_o), 32'd0);
        req_data_i  = $urandom;
        req_mode_i  = 2'($urandom);
        req_amt_i   = 5'($urandom);
        req_valid_i = 1'b1;
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        chk_eq("full_pop_only", 32'(req_ready_o), 32'd1);
        step();
        req_valid_i = 1'b0;
        chk_eq("full_refilled", 32'(req_ready_o), 32'd0);
        rsp_ready_i = 1'b1;
        repeat (5) step();
        rsp_ready_i = 1'b0;
        chk_eq("full_drained", 32'(rsp_valid_o), 32'd0);

        // Continuous flow across pointer wrap
        clear_cnt();
        stream(20);
        chk_eq("stream_cnt", 32'(cnt_o), 32'd20);

        // Counter saturation and clear priority
        clear_cnt();
        stream(65534);
        chk_eq("sat_pre", 32'(cnt_o), 32'h0000_FFFE);
        stream(3);
        chk_eq("sat_hold", 32'(cnt_o), 32'h0000_FFFF);
        send($urandom, 2'($urandom), 5'($urandom));
        rsp_ready_i = 1'b1;
        cnt_clr_i   = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        cnt_clr_i   = 1'b0;
        chk_eq("clr_priority", 32'(cnt_o), 32'd0);
        chk_eq("clr_popped", 32'(rsp_valid_o), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            req_valid_i = 1'($urandom);
            rsp_ready_i = 1'($urandom);
            req_data_i  = $urandom;
            req_mode_i  = 2'($urandom);
            req_amt_i   = 5'($urandom);
            cnt_clr_i   = ($urandom_range(0, 31) == 0);
            step();
        end
        req_valid_i = 1'b0;
        cnt_clr_i   = 1'b0;
        rsp_ready_i = 1'b1;
        repeat (6) step();
        rsp_ready_i = 1'b0;

`ifdef HELLO_WORLD_XFORM_PARITY_EN
        send(32'h0000_0007, 2'd0, 5'd0);
        chk_eq("parity_bit", 32'(rsp_parity_o), 32'd1);
        pop_expect("parity_data", 32'hFFFF_FFF8);
`endif

        // Asynchronous reset with entries in flight
        send($urandom, 2'($urandom), 5'($urandom));
        pop_expect("pre_rst", rsp_data_o);
        for (int i = 0; i < 3; i++) send($urandom, 2'($urandom), 5'($urandom));
        chk_eq("pre_rst_cnt_nonzero", 32'(cnt_o != 16'd0), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk_eq("arst_valid", 32'(rsp_valid_o), 32'd0);
        chk_eq("arst_busy", 32'(busy_o), 32'd0);
        chk_eq("arst_cnt", 32'(cnt_o), 32'd0);
        chk_eq("arst_data", rsp_data_o, 32'd0);
        step();
        rst_ni = 1'b1;
        step();
        chk_eq("post_rst_ready", 32'(req_ready_o), 32'd1);
        chk_eq("post_rst_empty", 32'(rsp_valid_o), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
